// File: rtl/knn_batch_seq_if.sv
// Core-side handshake bundle between knn_batch_seq (master) and a knn_core (slave).
interface knn_batch_seq_if #(
  parameter int WDATA_W = 32
);
  logic [8*WDATA_W-1:0] core_data;
  logic [WDATA_W-1:0]   core_test;
  logic                 core_start;
  logic                 core_valid;
  logic                 core_sample;
  logic                 core_valid_out;

  modport master (
    output core_data, core_test, core_start, core_valid, core_sample,
    input  core_valid_out
  );

  modport slave (
    input  core_data, core_test, core_start, core_valid, core_sample,
    output core_valid_out
  );
endinterface

// File: rtl/knn_batch_seq.sv
// Batches a software-loaded point buffer into 8-wide knn_core passes and
// reports completion/error back to the register bank.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | waiting for go; illegal counts flag err and pulse done here
// S_LOAD   | register the current batch (pad beyond num_pts) and test point
// S_START  | core_start/core_valid high for this single cycle
// S_WAIT   | hold batch, wait for core_valid_out or timeout
// S_SAMPLE | core_sample pulse after the final batch
// S_DONE   | done pulse; busy drops on the following cycle
module knn_batch_seq #(
  parameter int                 WDATA_W     = 32,
  parameter int                 MAX_PTS     = 64,
  parameter int                 ADDR_W      = 6,
  parameter int                 TIMEOUT_CYC = 1024,
  parameter logic [WDATA_W-1:0] PAD_VAL     = {WDATA_W{1'b1}}
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WDATA_W-1:0]  wr_data,
  input  logic [ADDR_W:0]     num_pts,
  input  logic [WDATA_W-1:0]  test_pt,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [ADDR_W-3:0]   batch_idx,
  knn_batch_seq_if.master     core
);

  localparam int CNT_W = ADDR_W + 1;
  localparam int BIX_W = ADDR_W - 2;
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PTS);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_SAMPLE, S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 start_q, start_d;
  logic                 valid_q, valid_d;
  logic                 sample_q, sample_d;
  logic [8*WDATA_W-1:0] data_q, data_d;
  logic [WDATA_W-1:0]   test_q, test_d;
  logic [WDATA_W-1:0]   tpt_q, tpt_d;
  logic [BIX_W-1:0]     bidx_q, bidx_d;
  logic [CNT_W-1:0]     num_q, num_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;

  logic [WDATA_W-1:0]   mem_q [MAX_PTS];
  logic [8*WDATA_W-1:0] load_data;
  logic [CNT_W:0]       slot_pos;
  logic [CNT_W:0]       next_base;
  logic                 last_batch;

  always_ff @(posedge clk) begin
    if (wr_en && !busy_q) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    load_data = '0;
    slot_pos  = '0;
    for (int i = 0; i < 8; i++) begin
      slot_pos = {1'b0, bidx_q, 3'b000} + (CNT_W+1)'(i);
      if (slot_pos < {1'b0, num_q}) begin
        load_data[i*WDATA_W +: WDATA_W] = mem_q[slot_pos[ADDR_W-1:0]];
      end else begin
        load_data[i*WDATA_W +: WDATA_W] = PAD_VAL;
      end
    end
  end

  // Extra top bit keeps 8*(batch_idx+1) from wrapping at a full buffer.
  assign next_base  = {1'b0, bidx_q, 3'b000} + (CNT_W+1)'(8);
  assign last_batch = next_base >= {1'b0, num_q};

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    start_d  = 1'b0;
    valid_d  = 1'b0;
    sample_d = 1'b0;
    data_d   = data_q;
    test_d   = test_q;
    tpt_d    = tpt_q;
    bidx_d   = bidx_q;
    num_d    = num_q;
    tmr_d    = tmr_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          if (num_pts != '0 && num_pts <= MAX_CNT) begin
            num_d   = num_pts;
            tpt_d   = test_pt;
            err_d   = 1'b0;
            busy_d  = 1'b1;
            bidx_d  = '0;
            state_d = S_LOAD;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        data_d  = load_data;
        test_d  = tpt_q;
        start_d = 1'b1;
        valid_d = 1'b1;
        state_d = S_START;
      end
      S_START: begin
        tmr_d   = TMR_LOAD;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A valid-out landing on the expiry cycle still wins over the timeout.
        if (core.core_valid_out) begin
          if (last_batch) begin
            sample_d = 1'b1;
            state_d  = S_SAMPLE;
          end else begin
            bidx_d  = bidx_q + BIX_W'(1);
            state_d = S_LOAD;
          end
        end else if (tmr_q == '0) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SAMPLE: begin
        done_d  = 1'b1;
        state_d = S_DONE;
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      start_q  <= 1'b0;
      valid_q  <= 1'b0;
      sample_q <= 1'b0;
      data_q   <= '0;
      test_q   <= '0;
      tpt_q    <= '0;
      bidx_q   <= '0;
      num_q    <= '0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      start_q  <= start_d;
      valid_q  <= valid_d;
      sample_q <= sample_d;
      data_q   <= data_d;
      test_q   <= test_d;
      tpt_q    <= tpt_d;
      bidx_q   <= bidx_d;
      num_q    <= num_d;
      tmr_q    <= tmr_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign batch_idx        = bidx_q;
  assign core.core_data   = data_q;
  assign core.core_test   = test_q;
  assign core.core_start  = start_q;
  assign core.core_valid  = valid_q;
  assign core.core_sample = sample_q;

endmodule

// File: tb/tb_knn_batch_seq.sv
// Self-checking bench for knn_batch_seq: a delayed-handshake core model plus a
// batch-level reference built from the buffer contents and num_pts.
module tb_knn_batch_seq;
  localparam int W   = 32;
  localparam int MP  = 64;
  localparam int AW  = 6;
  localparam int TMO = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [W-1:0]  wr_data = '0;
  logic [AW:0]   num_pts = '0;
  logic [W-1:0]  test_pt = '0;
  logic          go = 1'b0;
  logic          busy, done, err;
  logic [AW-3:0] batch_idx;

  knn_batch_seq_if #(.WDATA_W(W)) core_if ();

  knn_batch_seq #(
    .WDATA_W(W), .MAX_PTS(MP), .ADDR_W(AW), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .num_pts(num_pts), .test_pt(test_pt), .go(go), .busy(busy), .done(done),
    .err(err), .batch_idx(batch_idx), .core(core_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  int cyc = 0;
  int n_start, n_valid, n_sample, n_done;
  int go_cyc, vo_cyc, done_cyc, sample_cyc, hold_err;
  int vo_delay = -1;
  int vo_cnt = 0;
  logic [8*W-1:0] snap_data[$];
  int             snap_idx[$];
  int             snap_cyc[$];
  logic [W-1:0]   mem_model [MP];

  // Monitor and core model share one process so cycle stamps never race.
  always @(negedge clk) begin
    cyc++;
    if (go && !busy) go_cyc = cyc;
    if (core_if.core_start) begin
      n_start++;
      snap_data.push_back(core_if.core_data);
      snap_idx.push_back(int'(batch_idx));
      snap_cyc.push_back(cyc);
    end
    if (core_if.core_valid) n_valid++;
    if (core_if.core_sample) begin
      n_sample++;
      sample_cyc = cyc;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    core_if.core_valid_out = 1'b0;
    if (!rst) begin
      vo_cnt = 0;
    end else begin
      if (vo_cnt > 0) begin
        vo_cnt--;
        if (vo_cnt == 0) begin
          core_if.core_valid_out = 1'b1;
          vo_cyc = cyc;
          if (snap_data.size() > 0 && core_if.core_data !== snap_data[$]) hold_err++;
        end
      end
      if (core_if.core_start && vo_delay > 0) vo_cnt = vo_delay;
    end
  end

  function automatic logic [8*W-1:0] exp_batch(input int b, input int n);
    logic [8*W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (8*b + i < n) r[i*W +: W] = mem_model[8*b + i];
      else             r[i*W +: W] = {W{1'b1}};
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_pt(input int a, input logic [W-1:0] d);
    tick();
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    mem_model[a] = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic clear_mon();
    n_start = 0; n_valid = 0; n_sample = 0; n_done = 0;
    go_cyc = -100; vo_cyc = -100; done_cyc = -100; sample_cyc = -100; hold_err = 0;
    snap_data.delete(); snap_idx.delete(); snap_cyc.delete();
  endtask

  task automatic start_run(input int n, input logic [W-1:0] tp, input int dly);
    tick();
    clear_mon();
    vo_delay = dly;
    num_pts  = (AW+1)'(n);
    test_pt  = tp;
    go       = 1'b1;
    tick();
    go = 1'b0;
  endtask

  task automatic wait_done(input int limit, input string name);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < limit) begin
      @(posedge clk);
      k++;
    end
    n_tests++;
    if (n_done == n0) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, want one", name, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
    n_tests++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %0b want 0", err); end
    n_tests++; if ({core_if.core_start, core_if.core_valid, core_if.core_sample} !== 3'b000) begin
      n_fail++; $display("FAIL reset_pulses: got %b want 000", {core_if.core_start, core_if.core_valid, core_if.core_sample});
    end
    n_tests++; if (core_if.core_data !== '0 || core_if.core_test !== '0 || batch_idx !== '0) begin
      n_fail++; $display("FAIL reset_data: data %h test %h idx %0d want zeros", core_if.core_data, core_if.core_test, batch_idx);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_single_batch();
    for (int i = 0; i < 8; i++) write_pt(i, W'(10 + i));
    start_run(8, W'(5), 4);
    wait_done(200, "single");
    @(negedge clk);
    n_tests++; if (n_start !== 1 || n_valid !== 1) begin n_fail++; $display("FAIL single_pulses: start %0d valid %0d want 1 1", n_start, n_valid); end
    n_tests++; if (snap_data.size() < 1 || snap_data[0] !== exp_batch(0, 8)) begin n_fail++; $display("FAIL single_data: got %h want %h", (snap_data.size() > 0) ? snap_data[0] : '0, exp_batch(0, 8)); end
    n_tests++; if (snap_cyc.size() < 1 || snap_cyc[0] !== go_cyc + 2) begin n_fail++; $display("FAIL single_start_lat: got %0d want %0d", (snap_cyc.size() > 0) ? snap_cyc[0] : -1, go_cyc + 2); end
    n_tests++; if (n_sample !== 1 || sample_cyc !== vo_cyc + 1) begin n_fail++; $display("FAIL single_sample: count %0d cyc %0d want 1 at %0d", n_sample, sample_cyc, vo_cyc + 1); end
    n_tests++; if (done_cyc !== vo_cyc + 2) begin n_fail++; $display("FAIL single_done_lat: got %0d want %0d", done_cyc, vo_cyc + 2); end
    n_tests++; if (err !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL single_flags: err %0b busy %0b done %0b want 000", err, busy, done); end
    n_tests++; if (core_if.core_test !== W'(5)) begin n_fail++; $display("FAIL single_test_pt: got %0d want 5", core_if.core_test); end
    n_tests++; if (hold_err !== 0) begin n_fail++; $display("FAIL single_hold: got %0d changes want 0", hold_err); end
  endtask

  task automatic test_partial();
    for (int i = 0; i < 13; i++) write_pt(i, W'(1 + i));
    start_run(13, W'($urandom), 3);
    wait_done(200, "partial");
    @(negedge clk);
    n_tests++; if (n_start !== 2) begin n_fail++; $display("FAIL partial_batches: got %0d want 2", n_start); end
    for (int b = 0; b < 2 && b < snap_data.size(); b++) begin
      n_tests++; if (snap_data[b] !== exp_batch(b, 13)) begin n_fail++; $display("FAIL partial_data%0d: got %h want %h", b, snap_data[b], exp_batch(b, 13)); end
      n_tests++; if (snap_idx[b] !== b) begin n_fail++; $display("FAIL partial_idx%0d: got %0d want %0d", b, snap_idx[b], b); end
    end
    n_tests++; if (n_sample !== 1 || err !== 1'b0) begin n_fail++; $display("FAIL partial_end: samples %0d err %0b want 1 0", n_sample, err); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      int n = (it == 0) ? MP : int'($urandom_range(1, MP));
      int dly = int'($urandom_range(1, 8));
      int nb = (n + 7) / 8;
      for (int i = 0; i < MP; i++) write_pt(i, W'($urandom));
      start_run(n, W'($urandom), dly);
      wait_done(400, "random");
      @(negedge clk);
      n_tests++; if (n_start !== nb) begin n_fail++; $display("FAIL random_batches: n %0d got %0d want %0d", n, n_start, nb); end
      for (int b = 0; b < nb && b < snap_data.size(); b++) begin
        n_tests++; if (snap_data[b] !== exp_batch(b, n) || snap_idx[b] !== b) begin
          n_fail++; $display("FAIL random_batch%0d: n %0d idx %0d data %h want idx %0d data %h", b, n, snap_idx[b], snap_data[b], b, exp_batch(b, n));
        end
      end
      n_tests++; if (n_sample !== 1 || err !== 1'b0 || hold_err !== 0) begin
        n_fail++; $display("FAIL random_end: n %0d samples %0d err %0b holderr %0d want 1 0 0", n, n_sample, err, hold_err);
      end
    end
  endtask

  task automatic test_illegal();
    int bad [2] = '{0, MP + 1};
    for (int k = 0; k < 2; k++) begin
      start_run(bad[k], W'(0), 2);
      wait_done(10, "illegal");
      repeat (5) tick();
      @(negedge clk);
      n_tests++; if (done_cyc !== go_cyc + 1) begin n_fail++; $display("FAIL illegal_done_lat: n %0d got %0d want %0d", bad[k], done_cyc, go_cyc + 1); end
      n_tests++; if (err !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL illegal_flags: n %0d err %0b busy %0b want 1 0", bad[k], err, busy); end
      n_tests++; if (n_start !== 0 || n_valid !== 0 || n_sample !== 0) begin
        n_fail++; $display("FAIL illegal_core: n %0d start %0d valid %0d sample %0d want 0 0 0", bad[k], n_start, n_valid, n_sample);
      end
    end
    start_run(8, W'(3), 2);
    @(negedge clk);
    n_tests++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL illegal_clear: err %0b busy %0b want 0 1", err, busy); end
    wait_done(200, "illegal_recover");
  endtask

  task automatic test_timeout();
    start_run(8, W'(7), -1);
    wait_done(200, "timeout");
    repeat (2) tick();
    @(negedge clk);
    n_tests++; if (done_cyc !== go_cyc + 3 + TMO) begin n_fail++; $display("FAIL timeout_done_lat: got %0d want %0d", done_cyc, go_cyc + 3 + TMO); end
    n_tests++; if (err !== 1'b1 || n_sample !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL timeout_flags: err %0b samples %0d busy %0b want 1 0 0", err, n_sample, busy);
    end
    start_run(8, W'(7), TMO);
    wait_done(200, "timeout_edge");
    @(negedge clk);
    n_tests++; if (err !== 1'b0 || n_sample !== 1 || done_cyc !== vo_cyc + 2) begin
      n_fail++; $display("FAIL timeout_edge_ok: err %0b samples %0d done %0d want 0 1 %0d", err, n_sample, done_cyc, vo_cyc + 2);
    end
    start_run(8, W'(7), TMO + 1);
    wait_done(200, "timeout_late");
    repeat (3) tick();
    @(negedge clk);
    n_tests++; if (err !== 1'b1 || n_sample !== 0 || n_done !== 1) begin
      n_fail++; $display("FAIL timeout_late: err %0b samples %0d dones %0d want 1 0 1", err, n_sample, n_done);
    end
  endtask

  task automatic test_reset_wait();
    for (int i = 0; i < 8; i++) write_pt(i, W'($urandom));
    start_run(8, W'(9), -1);
    repeat (4) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if ({busy, done, err, core_if.core_start, core_if.core_valid, core_if.core_sample} !== 6'b0) begin
      n_fail++; $display("FAIL rstwait_flags: got %b want 000000", {busy, done, err, core_if.core_start, core_if.core_valid, core_if.core_sample});
    end
    n_tests++; if (core_if.core_data !== '0 || core_if.core_test !== '0 || batch_idx !== '0) begin
      n_fail++; $display("FAIL rstwait_data: data %h test %h idx %0d want zeros", core_if.core_data, core_if.core_test, batch_idx);
    end
    repeat (30) tick();
    n_tests++; if (n_done !== 0 || n_sample !== 0) begin n_fail++; $display("FAIL rstwait_no_done: dones %0d samples %0d want 0 0", n_done, n_sample); end
    start_run(8, W'(9), 3);
    wait_done(200, "rstwait_rerun");
    @(negedge clk);
    n_tests++; if (snap_data.size() < 1 || snap_data[0] !== exp_batch(0, 8) || err !== 1'b0) begin
      n_fail++; $display("FAIL rstwait_rerun: got %h err %0b want %h err 0", (snap_data.size() > 0) ? snap_data[0] : '0, err, exp_batch(0, 8));
    end
  endtask

  task automatic test_busy_write();
    start_run(8, W'(4), 6);
    repeat (2) tick();
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = ~mem_model[0];
    go      = 1'b1;
    num_pts = (AW+1)'(3);
    tick();
    wr_en = 1'b0;
    go    = 1'b0;
    wait_done(200, "busywr");
    repeat (6) tick();
    n_tests++; if (n_done !== 1 || n_start !== 1) begin n_fail++; $display("FAIL busywr_single: dones %0d starts %0d want 1 1", n_done, n_start); end
    start_run(8, W'(4), 2);
    wait_done(200, "busywr_rerun");
    @(negedge clk);
    n_tests++; if (snap_data.size() < 1 || snap_data[0] !== exp_batch(0, 8)) begin
      n_fail++; $display("FAIL busywr_mem: got %h want %h", (snap_data.size() > 0) ? snap_data[0] : '0, exp_batch(0, 8));
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_single_batch();
    test_partial();
    test_random();
    test_illegal();
    test_timeout();
    test_reset_wait();
    test_busy_write();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/knn_batch_seq.md
Name: knn_batch_seq

Overview:
- Sequencer that feeds a knn_core instance when the data set is larger than its 8 parallel data-point inputs.
- Holds up to MAX_PTS data points in an internal buffer loaded by software.
- On a go command, presents the points to the core in batches of 8, pulses start/valid per batch and waits for the core's valid-out handshake.
- After the last batch, pulses sample so the core publishes its K-nearest results; reports done/err back to the software register bank.

Parameters:
WDATA_W, 32, data/test point width
MAX_PTS, 64, buffer depth in points (multiple of 8)
ADDR_W, 6, log2(MAX_PTS)
TIMEOUT_CYC, 1024, max cycles to wait for core valid-out per batch
PAD_VAL, all ones (WDATA_W bits), value driven on unused slots of a partial batch

Ports:
clk  in  1  clock, all logic rising-edge
rst  in  1  synchronous, active-low reset
wr_en  in  1  buffer write strobe, honoured only when busy=0
wr_addr  in  ADDR_W  buffer write index
wr_data  in  WDATA_W  data point to write
num_pts  in  ADDR_W+1  number of valid points, sampled on go
test_pt  in  WDATA_W  test point, sampled on go
go  in  1  start request, one-cycle pulse
busy  out  1  high from go acceptance until done
done  out  1  one-cycle completion pulse
err  out  1  sticky error flag, cleared on next accepted go
batch_idx  out  ADDR_W-2  index of the batch currently presented
core_data  out  8*WDATA_W  slot i in bits [i*WDATA_W +: WDATA_W]
core_test  out  WDATA_W  test point to the core
core_start  out  1  core start pulse
core_valid  out  1  core valid-in pulse
core_sample  out  1  core sample pulse
core_valid_out  in  1  core batch-complete handshake

Behaviour:
- Reset (rst=0 at a clock edge):
  - State goes to IDLE.
  - busy, done, err, core_start, core_valid and core_sample all go to 0.
  - core_data, core_test and batch_idx go to 0.
  - Buffer contents are not reset.
- Reset mid-operation aborts immediately. No sample pulse is issued and no done pulse is issued.
- Buffer writes:
  - Registered; a write at edge t is readable from t+1.
  - wr_en while busy=1 is ignored.
- State IDLE:
  - go=1 with 1<=num_pts<=MAX_PTS: latch num_pts and test_pt, clear err, set busy=1, batch_idx=0, go to LOAD.
  - go=1 with num_pts=0 or num_pts>MAX_PTS: err=1, done pulse on the next cycle, no core activity, stay IDLE.
- State LOAD (1 cycle):
  - Register core_data slot i = buf[8*batch_idx+i] if 8*batch_idx+i < num_pts, else PAD_VAL.
  - Register core_test = latched test point.
  - Go to START.
- State START (1 cycle): core_start=1 and core_valid=1 for exactly this cycle. Go to WAIT.
- State WAIT:
  - core_data and core_test are held stable.
  - The timeout counter clears on entry and increments each cycle.
  - core_valid_out=1: if 8*(batch_idx+1) >= num_pts go to SAMPLE; else increment batch_idx and go to LOAD.
  - Counter reaches TIMEOUT_CYC-1 without valid-out: err=1, go to DONE (SAMPLE is skipped).
- State SAMPLE (1 cycle): core_sample=1, go to DONE.
- State DONE (1 cycle): done=1, busy=0 on the next cycle, go to IDLE.
- go while busy=1 is ignored.
- core_valid_out outside WAIT is ignored.
- core_valid_out on the same cycle as timeout expiry counts as success.
- Latency:
  - go accepted at edge 0 → LOAD cycle 1, core_start high in cycle 2, WAIT from cycle 3.
  - Last valid-out sampled in cycle t → core_sample in t+1, done in t+2.
- Batch count = ceil(num_pts/8). num_pts=MAX_PTS gives exactly MAX_PTS/8 batches, with no wrap of the index.

Test Plan:
- Single batch: write 8 points 10..17, num_pts=8, test_pt=5, go; core model asserts valid-out 4 cycles after start → exactly one start/valid pulse, core_data = 10..17, one sample pulse, done 2 cycles after valid-out, err=0.
- Partial batch: num_pts=13, points 1..13 → two batches; batch 1 slots = 9..13, slots 5..7 = 0xFFFFFFFF; batch_idx 0 then 1; one sample pulse.
- Illegal count: num_pts=0, then num_pts=65 → each gives err=1 and a done pulse; core_start, core_valid and core_sample never asserted; err clears on the next legal go.
- Timeout: core model never asserts valid-out, TIMEOUT_CYC=16 → err=1, done 1 cycle after expiry, no sample pulse, busy drops.
- Reset in WAIT: assert rst=0 for 1 cycle mid-batch → all outputs 0 the next cycle, no done; a new go with unchanged buffer completes normally.
- Write/go while busy: wr_en to addr 0 and a second go during WAIT → buffer entry unchanged in a later run, single done pulse.
